// File: rtl/seg_scan_if.sv
// Write port of the display scan sequencer: shadow-buffer writes and the
// commit/pending handshake between the key/control logic and seg_scan_ctrl.
interface seg_scan_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic       commit;
  logic       commit_pending;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output commit,
    input  wr_ready,
    input  commit_pending
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  commit,
    output wr_ready,
    output commit_pending
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan sequencer for a multiplexed 7-segment display: double-buffered digit
// frame, per-digit dwell with an all-off blank gap, swap only at frame edges.
module seg_scan_ctrl #(
  parameter int unsigned F_CLK     = 50_000_000,
  parameter int unsigned F_SCAN    = 1000,
  parameter int unsigned N_DIG     = 8,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  seg_scan_if.slave      wr,
  output logic [7:0]     cs,
  output logic [4:0]     dig_ctrl,
  output logic           frame_done
);

  localparam int unsigned DWELL = F_CLK / F_SCAN;
  localparam int unsigned TW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned PW    = 3;
  localparam int unsigned DW    = 5;
  localparam int unsigned CW    = 8;

  localparam logic [TW-1:0] T_LAST      = TW'(DWELL - 1);
  localparam logic [TW-1:0] T_SHOW_LAST = TW'(DWELL - BLANK_CYC - 1);
  localparam logic [PW-1:0] P_LAST      = PW'(N_DIG - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   ptr_step;
  logic [DW-1:0]   shadow [CW];
  logic [DW-1:0]   active [CW];

  logic            pending;
  logic            pending_nxt;
  logic            boundary;
  logic            swap;
  logic            wr_fire;
  logic            addr_ok;
  logic            fd_nxt;

  assign pending = wr.commit_pending;

  // Digit pointer advance with wrap at the last scanned digit.
  always_comb begin
    ptr_step = ptr + PW'(1);
    if (ptr == P_LAST) begin
      ptr_step = '0;
    end
  end

  // Scan walk: dwell timer, digit pointer and show/blank phase.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    ptr_nxt   = ptr;
    if (!en) begin
      state_nxt = IDLE;
      timer_nxt = '0;
      ptr_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SHOW;
          timer_nxt = '0;
          ptr_nxt   = '0;
        end
        SHOW: begin
          if (timer == T_SHOW_LAST) begin
            if (BLANK_CYC == 0) begin
              timer_nxt = '0;
              ptr_nxt   = ptr_step;
            end else begin
              state_nxt = BLANK;
              timer_nxt = timer + TW'(1);
            end
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        BLANK: begin
          if (timer == T_LAST) begin
            state_nxt = SHOW;
            timer_nxt = '0;
            ptr_nxt   = ptr_step;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
          ptr_nxt   = '0;
        end
      endcase
    end
  end

  // Frame edge, swap decision and write acceptance; writes are only
  // accepted while no swap is pending, so a swap never races a write.
  always_comb begin
    boundary    = (state != IDLE) && (timer == T_LAST) && (ptr == P_LAST);
    swap        = pending && ((state == IDLE) || boundary);
    wr_fire     = wr.wr_valid && !pending;
    addr_ok     = 32'(wr.wr_addr) < N_DIG;
    pending_nxt = swap ? wr.commit : (pending | wr.commit);
    fd_nxt      = (state_nxt != IDLE) && (timer_nxt == T_LAST) && (ptr_nxt == P_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      timer             <= '0;
      ptr               <= '0;
      wr.commit_pending <= 1'b0;
      wr.wr_ready       <= 1'b1;
      frame_done        <= 1'b0;
      cs                <= 8'hFF;
      dig_ctrl          <= '0;
      for (int i = 0; i < int'(CW); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      state             <= state_nxt;
      timer             <= timer_nxt;
      ptr               <= ptr_nxt;
      wr.commit_pending <= pending_nxt;
      wr.wr_ready       <= !pending_nxt;
      frame_done        <= fd_nxt;

      if (wr_fire && addr_ok) begin
        shadow[wr.wr_addr] <= wr.wr_data;
      end
      if (swap) begin
        for (int i = 0; i < int'(CW); i++) begin
          active[i] <= shadow[i];
        end
      end

      // The first digit after a swap must already show the new frame.
      if (state_nxt == SHOW) begin
        cs       <= ~(CW'(1) << ptr_nxt);
        dig_ctrl <= swap ? shadow[ptr_nxt] : active[ptr_nxt];
      end else begin
        cs       <= 8'hFF;
        dig_ctrl <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: two builds (8 digits with blank gap,
// 6 digits without) driven by the same directed stimulus.
module tb_seg_scan_ctrl;

  localparam int DWELL = 10;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] vec;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       wr_valid;
  logic       commit;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;

  logic [7:0] cs_a, cs_b;
  logic [4:0] dig_a, dig_b;
  logic       fd_a, fd_b;

  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];

  seg_scan_if ifa ();
  seg_scan_if ifb ();

  assign ifa.wr_valid = wr_valid;
  assign ifa.wr_addr  = wr_addr;
  assign ifa.wr_data  = wr_data;
  assign ifa.commit   = commit;
  assign ifb.wr_valid = wr_valid;
  assign ifb.wr_addr  = wr_addr;
  assign ifb.wr_data  = wr_data;
  assign ifb.commit   = commit;

  seg_scan_ctrl #(.F_CLK(1000), .F_SCAN(100), .N_DIG(8), .BLANK_CYC(2)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr         (ifa.slave),
    .cs         (cs_a),
    .dig_ctrl   (dig_a),
    .frame_done (fd_a)
  );

  seg_scan_ctrl #(.F_CLK(1000), .F_SCAN(100), .N_DIG(6), .BLANK_CYC(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr         (ifb.slave),
    .cs         (cs_b),
    .dig_ctrl   (dig_b),
    .frame_done (fd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: scan position within the frame, buffers and pending flag.
  bit         m_scan [2];
  int         m_pos  [2];
  bit         m_pend [2];
  logic [4:0] m_sh   [2][8];
  logic [4:0] m_act  [2][8];
  logic [15:0] m_prev [2];

  function automatic int nd_of(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic int bl_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic [15:0] obs(input int k);
    if (k == 0) return {cs_a, dig_a, fd_a, ifa.wr_ready, ifa.commit_pending};
    return {cs_b, dig_b, fd_b, ifb.wr_ready, ifb.commit_pending};
  endfunction

  task automatic push_exp(input int k, input logic [15:0] v);
    exp_t e;
    e.cyc = 32'(cyc + 1);
    e.vec = v;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Expected outputs after the coming edge, from the inputs now applied.
  task automatic model_step(input int k);
    int fl;
    int ptr;
    int t;
    bit bnd;
    bit swp;
    logic [7:0] one;
    logic [7:0] e_cs;
    logic [4:0] e_dig;
    logic [15:0] v;
    fl  = nd_of(k) * DWELL;
    one = 8'h01;
    if (!rst_n) begin
      m_scan[k] = 1'b0;
      m_pos[k]  = 0;
      m_pend[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_sh[k][i]  = 5'h00;
        m_act[k][i] = 5'h00;
      end
    end else begin
      bnd = m_scan[k] && (m_pos[k] == fl - 1);
      swp = m_pend[k] && (!m_scan[k] || bnd);
      if (wr_valid && !m_pend[k] && (int'(wr_addr) < nd_of(k))) m_sh[k][wr_addr] = wr_data;
      if (swp) begin
        for (int i = 0; i < 8; i++) m_act[k][i] = m_sh[k][i];
      end
      m_pend[k] = swp ? commit : (m_pend[k] | commit);
      if (!en) begin
        m_scan[k] = 1'b0;
        m_pos[k]  = 0;
      end else if (!m_scan[k]) begin
        m_scan[k] = 1'b1;
        m_pos[k]  = 0;
      end else begin
        m_pos[k] = (m_pos[k] + 1) % fl;
      end
    end
    ptr = m_pos[k] / DWELL;
    t   = m_pos[k] % DWELL;
    if (m_scan[k] && (t < DWELL - bl_of(k))) begin
      e_cs  = ~(one << ptr);
      e_dig = m_act[k][ptr];
    end else begin
      e_cs  = 8'hFF;
      e_dig = 5'h00;
    end
    v = {e_cs, e_dig, (m_scan[k] && (m_pos[k] == fl - 1)), !m_pend[k], m_pend[k]};
    if (v !== m_prev[k]) push_exp(k, v);
    m_prev[k] = v;
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write(input logic [2:0] a, input logic [4:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    cycle();
    commit = 1'b0;
  endtask

  // Monitor: every change of a DUT's outputs is matched against the scoreboard.
  logic [15:0] seen [2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [15:0] v;
      exp_t e;
      v = obs(k);
      if (v !== seen[k]) begin
        seen[k] = v;
        n_cmp++;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          n_bad++;
          $display("FAIL change_dut%0d cyc %0d: got %h, required no change", k, cyc, v);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          if (e.cyc != 32'(cyc) || e.vec !== v) begin
            n_bad++;
            $display("FAIL scan_dut%0d: got cyc %0d cs %h dig %h fd/rdy/pend %b, required cyc %0d cs %h dig %h fd/rdy/pend %b",
                     k, cyc, v[15:8], v[7:3], v[2:0], e.cyc, e.vec[15:8], e.vec[7:3], e.vec[2:0]);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    rst_n    = 1'b0;
    en       = 1'b0;
    wr_valid = 1'b0;
    commit   = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 5'd0;
    for (int k = 0; k < 2; k++) begin
      m_prev[k] = 16'hxxxx;
      m_scan[k] = 1'b0;
      m_pos[k]  = 0;
      m_pend[k] = 1'b0;
    end

    run(2);
    rst_n = 1'b1;
    run(3);

    // Free-running scan of all-zero frames.
    en = 1'b1;
    run(100);

    // Mid-frame write and commit; a write while pending is refused.
    write(3'd3, 5'h1A);
    run(5);
    pulse_commit();
    run(3);
    write(3'd4, 5'h15);
    run(120);

    // Write accepted in the same cycle as commit.
    wr_valid = 1'b1;
    wr_addr  = 3'd2;
    wr_data  = 5'h07;
    commit   = 1'b1;
    cycle();
    wr_valid = 1'b0;
    commit   = 1'b0;
    run(180);

    // Idle swaps, including a commit landing on the swap cycle.
    en = 1'b0;
    run(3);
    write(3'd1, 5'h11);
    pulse_commit();
    pulse_commit();
    run(4);
    en = 1'b1;
    run(90);

    // Drop enable during digit 5 of the 8-digit build, then restart.
    guard = 0;
    while (m_pos[0] != 52 && guard < 200) begin
      cycle();
      guard++;
    end
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(30);

    // Address 7 exists only in the 8-digit build.
    write(3'd7, 5'h1F);
    pulse_commit();
    run(170);

    // Reset during a blank gap with a swap pending.
    write(3'd6, 5'h0C);
    pulse_commit();
    guard = 0;
    while ((m_pos[0] % DWELL) != 8 && guard < 200) begin
      cycle();
      guard++;
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    run(100);

    en = 1'b0;
    run(4);
    @(posedge clk);
    #1;
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d expected changes never seen, required 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
